// File: rtl/ad5676r_pkg.sv
// Shared command encodings and word builder for the AD5676R command path.
package ad5676r_pkg;

    localparam int DAC_WIDTH      = 24;
    localparam int DAC_CODE_WIDTH = 16;

    typedef enum logic [3:0] {
        CMD_NOP          = 4'h0,
        CMD_WRITE_UPDATE = 4'h3
    } dac_cmd_e;

    localparam logic [DAC_WIDTH-1:0] NOP_WORD = '0;

    // Word layout: command nibble, reserved zero, 3-bit channel address, code.
    function automatic logic [DAC_WIDTH-1:0] build_word(
        input dac_cmd_e                  cmd,
        input logic [2:0]                ch,
        input logic [DAC_CODE_WIDTH-1:0] code
    );
        return {cmd, 1'b0, ch, code};
    endfunction

endpackage

// File: rtl/ad5676r_channel_sequencer_rr_pick.sv
// Combinational round-robin picker: first requester after the last winner.
module rr_pick #(
    parameter int NUM_CH = 8,
    parameter int IW     = 3
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [IW-1:0]     last_i,
    output logic [IW-1:0]     grant_o,
    output logic              valid_o
);

    int idx;

    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        idx     = 0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = (int'(last_i) + i) % NUM_CH;
            if (!valid_o && req_i[IW'(idx)]) begin
                valid_o = 1'b1;
                grant_o = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/ad5676r_channel_sequencer.sv
// Holds host channel codes and emits one DAC command word per writer frame,
// sending only changed channels in round-robin order, NOP otherwise.
module ad5676r_channel_sequencer #(
    parameter int                    DATA_WIDTH  = 24,
    parameter int                    NUM_CH      = 8,
    parameter int                    CODE_WIDTH  = 16,
    parameter int                    SLOT_CYCLES = 27,
    parameter logic [CODE_WIDTH-1:0] RESET_CODE  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [2:0]            wr_ch,
    input  logic [CODE_WIDTH-1:0] wr_code,
    input  logic [NUM_CH-1:0]     ch_enable,
    output logic [DATA_WIDTH-1:0] da_data,
    output logic                  slot_strobe,
    output logic [2:0]            sent_ch,
    output logic                  sent_valid,
    output logic                  busy
);

    import ad5676r_pkg::*;

    localparam int              SW         = $clog2(SLOT_CYCLES);
    localparam logic [SW-1:0]   SLOT_LAST  = SW'(SLOT_CYCLES - 1);
    localparam logic [2:0]      LAST_RESET = 3'(NUM_CH - 1);

    logic [CODE_WIDTH-1:0] code_q [NUM_CH];
    logic [NUM_CH-1:0]     pending_q, pending_d;
    logic [SW-1:0]         slot_cnt_q;
    logic [2:0]            last_q;
    logic [DATA_WIDTH-1:0] da_data_q;
    logic                  slot_strobe_q, sent_valid_q, busy_q;
    logic [2:0]            sent_ch_q;

    logic                  load, wr_ok, grant_valid;
    logic [2:0]            grant;

    assign load  = (slot_cnt_q == SLOT_LAST);
    assign wr_ok = wr_en && (int'(wr_ch) < NUM_CH);

    rr_pick #(
        .NUM_CH (NUM_CH),
        .IW     (3)
    ) u_pick (
        .req_i   (pending_q & ch_enable),
        .last_i  (last_q),
        .grant_o (grant),
        .valid_o (grant_valid)
    );

    // A host write in the same cycle its channel is sent keeps the flag set,
    // so the freshly written code still goes out in a later slot.
    always_comb begin
        pending_d = pending_q;
        if (load && grant_valid) begin
            pending_d[grant] = 1'b0;
        end
        if (wr_ok) begin
            pending_d[wr_ch] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                code_q[i] <= RESET_CODE;
            end
            pending_q     <= '1;
            slot_cnt_q    <= '0;
            last_q        <= LAST_RESET;
            da_data_q     <= NOP_WORD;
            slot_strobe_q <= 1'b0;
            sent_ch_q     <= 3'd0;
            sent_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_ok && wr_ch == 3'(i)) begin
                    code_q[i] <= wr_code;
                end
            end
            pending_q     <= pending_d;
            slot_cnt_q    <= load ? '0 : slot_cnt_q + 1'b1;
            slot_strobe_q <= load;
            busy_q        <= |(pending_q & ch_enable);
            if (load) begin
                if (grant_valid) begin
                    da_data_q    <= build_word(CMD_WRITE_UPDATE, grant, code_q[grant]);
                    sent_ch_q    <= grant;
                    sent_valid_q <= 1'b1;
                    last_q       <= grant;
                end else begin
                    da_data_q    <= NOP_WORD;
                    sent_ch_q    <= 3'd0;
                    sent_valid_q <= 1'b0;
                end
            end
        end
    end

    assign da_data     = da_data_q;
    assign slot_strobe = slot_strobe_q;
    assign sent_ch     = sent_ch_q;
    assign sent_valid  = sent_valid_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_ad5676r_channel_sequencer.sv
// Self-checking bench: expected slot words queued at stimulus time, compared at each slot strobe.
module tb_ad5676r_channel_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_ch;
    logic [15:0] wr_code;
    logic [7:0]  ch_enable;
    logic [23:0] da_data;
    logic        slot_strobe;
    logic [2:0]  sent_ch;
    logic        sent_valid;
    logic        busy;

    always #5 clk = ~clk;

    ad5676r_channel_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_ch       (wr_ch),
        .wr_code     (wr_code),
        .ch_enable   (ch_enable),
        .da_data     (da_data),
        .slot_strobe (slot_strobe),
        .sent_ch     (sent_ch),
        .sent_valid  (sent_valid),
        .busy        (busy)
    );

    typedef struct {
        logic        wr_en;
        logic [2:0]  wr_ch;
        logic [15:0] wr_code;
        logic [7:0]  ch_enable;
        logic [23:0] exp_word;
        logic        exp_busy;
    } vec_t;

    vec_t        vecs [7];
    logic [23:0] exp_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          since    = 0;
    int          spacing  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        since++;
        if (slot_strobe) begin
            spacing = since;
            since   = 0;
        end
    endtask

    task automatic wait_slot();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!slot_strobe && n < 40);
        n_checks++;
        if (!slot_strobe) begin
            n_fail++;
            $display("FAIL slot_timeout: no slot_strobe after %0d cycles, expected one within 27", n);
        end
    endtask

    task automatic check_slot(input string name);
        logic [23:0] e;
        logic        ev;
        wait_slot();
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got da_data 0x%06h", name, da_data);
            return;
        end
        e  = exp_q.pop_front();
        ev = (e[23:20] == 4'h3);
        $display("slot %s: da_data=0x%06h expected=0x%06h sent_valid=%0b sent_ch=%0d spacing=%0d",
                 name, da_data, e, sent_valid, sent_ch, spacing);
        check({name, "_data"},    32'(da_data),    32'(e));
        check({name, "_valid"},   32'(sent_valid), 32'(ev));
        check({name, "_ch"},      32'(sent_ch),    ev ? 32'(e[18:16]) : 32'd0);
        check({name, "_spacing"}, 32'(spacing),    32'd27);
    endtask

    task automatic do_reset(input int cycles);
        rst   = 1'b1;
        wr_en = 1'b0;
        repeat (cycles) tick();
        check("rst_da_data",     32'(da_data),     32'h0);
        check("rst_slot_strobe", 32'(slot_strobe), 32'h0);
        check("rst_sent_valid",  32'(sent_valid),  32'h0);
        check("rst_sent_ch",     32'(sent_ch),     32'h0);
        rst   = 1'b0;
        since = 0;
        exp_q.delete();
    endtask

    task automatic push_resend();
        for (int c = 0; c < 8; c++) begin
            exp_q.push_back({4'h3, 1'b0, 3'(c), 16'h0000});
        end
        exp_q.push_back(24'h000000);
        exp_q.push_back(24'h000000);
    endtask

    initial begin
        rst       = 1'b1;
        wr_en     = 1'b0;
        wr_ch     = 3'd0;
        wr_code   = 16'h0000;
        ch_enable = 8'hFF;

        vecs[0] = '{1'b1, 3'd5, 16'hABCD, 8'hFF, 24'h35ABCD, 1'b1};
        vecs[1] = '{1'b0, 3'd0, 16'h0000, 8'hFF, 24'h000000, 1'b0};
        vecs[2] = '{1'b1, 3'd4, 16'h8000, 8'h00, 24'h000000, 1'b0};
        vecs[3] = '{1'b0, 3'd0, 16'h0000, 8'h00, 24'h000000, 1'b0};
        vecs[4] = '{1'b0, 3'd0, 16'h0000, 8'h10, 24'h348000, 1'b1};
        vecs[5] = '{1'b0, 3'd0, 16'h0000, 8'hFF, 24'h000000, 1'b0};
        vecs[6] = '{1'b1, 3'd3, 16'h0333, 8'hFF, 24'h330333, 1'b1};

        // Full resend of every channel after reset, then idle NOPs.
        do_reset(3);
        tick();
        tick();
        check("busy_after_reset", 32'(busy), 32'h1);
        push_resend();
        for (int i = 0; i < 10; i++) check_slot($sformatf("t1_%0d", i));

        // Single writes, disabled channel held pending, re-enable.
        for (int i = 0; i < 7; i++) begin
            ch_enable = vecs[i].ch_enable;
            wr_en     = vecs[i].wr_en;
            wr_ch     = vecs[i].wr_ch;
            wr_code   = vecs[i].wr_code;
            tick();
            wr_en = 1'b0;
            tick();
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            exp_q.push_back(vecs[i].exp_word);
            check_slot($sformatf("vec%0d", i));
        end

        // Three writes in one slot with last sent = 3: order 6, 1, 2.
        wr_en = 1'b1; wr_ch = 3'd2; wr_code = 16'h1111; tick();
        wr_ch = 3'd6; wr_code = 16'h2222; tick();
        wr_ch = 3'd1; wr_code = 16'h3333; tick();
        wr_en = 1'b0;
        exp_q.push_back(24'h362222);
        exp_q.push_back(24'h313333);
        exp_q.push_back(24'h321111);
        exp_q.push_back(24'h000000);
        for (int i = 0; i < 4; i++) check_slot($sformatf("t3_%0d", i));

        // Write to ch0 on the very load cycle that selects it.
        wr_en = 1'b1; wr_ch = 3'd0; wr_code = 16'h0000; tick();
        wr_en = 1'b0;
        repeat (25) tick();
        wr_en = 1'b1; wr_ch = 3'd0; wr_code = 16'h0001;
        exp_q.push_back(24'h300000);
        check_slot("t5_old");
        wr_en = 1'b0;
        exp_q.push_back(24'h300001);
        exp_q.push_back(24'h000000);
        check_slot("t5_new");
        check_slot("t5_nop");

        // Reset mid-slot while a channel word is on the bus.
        wr_en = 1'b1; wr_ch = 3'd2; wr_code = 16'h5555; tick();
        wr_ch = 3'd7; wr_code = 16'h7777; tick();
        wr_en = 1'b0;
        exp_q.push_back(24'h325555);
        check_slot("t6_pre");
        repeat (10) tick();
        do_reset(2);
        tick();
        tick();
        check("busy_after_reset2", 32'(busy), 32'h1);
        push_resend();
        for (int i = 0; i < 10; i++) check_slot($sformatf("t6_%0d", i));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1);
    end

endmodule
